// File: rtl/screen_clear_if.sv
// Start/config inputs from the I/O controller, VRAM write port and status for the
// screen clear engine.
interface screen_clear_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned ROW_W  = 5
);
  logic              clear_start;
  logic              mode;
  logic [15:0]       color_data;
  logic [ROW_W-1:0]  cursor_row;
  logic              vram_gnt;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [23:0]       vram_wdata;
  logic              busy;
  logic              done;

  modport master (
    output clear_start, mode, color_data, cursor_row, vram_gnt,
    input  vram_we, vram_addr, vram_wdata, busy, done
  );

  modport slave (
    input  clear_start, mode, color_data, cursor_row, vram_gnt,
    output vram_we, vram_addr, vram_wdata, busy, done
  );
endinterface

// File: rtl/screen_clear_engine.sv
// Sweeps text VRAM with blank cells: whole screen (mode=0) or one row (mode=1).
// All outputs are registered; the VRAM port is shared with the CPU through vram_gnt.
module screen_clear_engine #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned ROW_W      = 5,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input logic           clk,
  input logic           rst,
  screen_clear_if.slave bus
);

  // One extra bit so COLS*ROWS == 2**ADDR_W still fits in the cell counter.
  localparam int unsigned       CntW      = ADDR_W + 1;
  localparam logic [ROW_W-1:0]  MaxRow    = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ColsA     = ADDR_W'(COLS);
  localparam logic [CntW-1:0]   LineCnt   = CntW'(COLS);
  localparam logic [CntW-1:0]   ScreenCnt = CntW'(COLS * ROWS);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e            state_q;
  logic              prev_q;
  logic [CntW-1:0]   remaining_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       wdata_q;
  logic              busy_q;
  logic              done_q;

  logic              start_pulse;
  logic [ROW_W-1:0]  row_clamped;
  logic [ADDR_W-1:0] line_base;

  always_comb begin
    start_pulse = bus.clear_start & ~prev_q;
    row_clamped = (bus.cursor_row > MaxRow) ? MaxRow : bus.cursor_row;
    line_base   = ADDR_W'(row_clamped) * ColsA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      prev_q      <= 1'b1;  // a level already high at reset release is not an edge
      remaining_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      prev_q <= bus.clear_start;
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_pulse) begin
            state_q <= StClear;
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
            wdata_q <= {BLANK_CHAR, bus.color_data};
            if (bus.mode) begin
              addr_q      <= line_base;
              remaining_q <= LineCnt;
            end else begin
              addr_q      <= '0;
              remaining_q <= ScreenCnt;
            end
          end
        end
        StClear: begin
          // Without a grant everything holds, so the pending write stays stable.
          if (bus.vram_gnt) begin
            if (remaining_q == CntW'(1)) begin
              state_q <= StDone;
              we_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q      <= addr_q + ADDR_W'(1);
              remaining_q <= remaining_q - CntW'(1);
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.vram_we    = we_q;
  assign bus.vram_addr  = addr_q;
  assign bus.vram_wdata = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
